// File: rtl/rdma_rx_remap.sv
`timescale 1ns/1ps
// rdma_rx_remap: inbound remote->local address remap with window check.
// Accepted requests inside [OFFSET, OFFSET+WIN_BYTES) are translated to
// local addresses and queued in a small FIFO toward the local memory port;
// everything else is routed, untranslated, to a single-entry error channel.
// A single capture stage in front keeps strict request order across both
// destinations.
// Optional feature: define RDMA_RX_STATS_EN to build the saturating
// accept/reject counters; without it cnt_ok/cnt_err are constant zero.
module rdma_rx_remap #(
    parameter logic [31:0] OFFSET    = 32'h8000_0000,
    parameter logic [31:0] WIN_BYTES = 32'h1000_0000,
    parameter int          LEN_W     = 12,
    parameter int          DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_write,
    output logic             loc_valid,
    input  logic             loc_ready,
    output logic [31:0]      loc_addr,
    output logic [LEN_W-1:0] loc_len,
    output logic             loc_write,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [31:0]      err_addr,
    output logic [15:0]      cnt_ok,
    output logic [15:0]      cnt_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + LEN_W + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic             r_vld_p1;
    logic [31:0]      r_addr_p1;
    logic [LEN_W-1:0] r_len_p1;
    logic             r_write_p1;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic             r_err_valid;
    logic [31:0]      r_err_addr;

    logic [31:0]      w_local;
    logic [32:0]      w_end;
    logic             w_ok;
    logic [AW:0]      w_count;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_err_load;
    logic             w_adv_p1;

    // Window check in 33 bits so a request running past 2^32 cannot wrap
    // back into the window.
    assign w_local  = r_addr_p1 - OFFSET;
    assign w_end    = {1'b0, w_local} + {{(33-LEN_W){1'b0}}, r_len_p1};
    assign w_ok     = (r_addr_p1 >= OFFSET) && (r_len_p1 != '0) &&
                      (w_end <= {1'b0, WIN_BYTES});

    // Fullness is judged after this cycle's pop so a full FIFO that is
    // draining can still take the next push in the same cycle.
    assign w_count    = r_wptr - r_rptr;
    assign loc_valid  = (w_count != '0);
    assign w_pop      = loc_valid && loc_ready;
    assign w_full     = (w_count == FULL_CNT) && !w_pop;

    // Stage 1 only advances into its own destination; a busy destination
    // stalls it even when the other channel is idle, preserving order.
    assign w_push     = r_vld_p1 && w_ok && !w_full;
    assign w_err_load = r_vld_p1 && !w_ok && (!r_err_valid || err_ready);
    assign w_adv_p1   = w_push || w_err_load;
    assign req_ready  = !r_vld_p1 || w_adv_p1;

    assign {loc_addr, loc_len, loc_write} = r_mem[r_rptr[AW-1:0]];
    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;

    // Stage 1 capture register: holds one request until its destination frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_addr_p1  <= '0;
            r_len_p1   <= '0;
            r_write_p1 <= 1'b0;
        end else if (req_valid && req_ready) begin
            r_vld_p1   <= 1'b1;
            r_addr_p1  <= req_addr;
            r_len_p1   <= req_len;
            r_write_p1 <= req_write;
        end else if (w_adv_p1) begin
            r_vld_p1   <= 1'b0;
        end
    end

    // Output FIFO of translated requests; the extra pointer bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= {w_local, r_len_p1, r_write_p1};
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Single-entry error channel carrying the untranslated remote address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if (w_err_load) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr_p1;
        end else if (err_ready) begin
            r_err_valid <= 1'b0;
        end
    end

`ifdef RDMA_RX_STATS_EN
    logic [15:0] r_cnt_ok;
    logic [15:0] r_cnt_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating accept/reject counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else begin
            if (w_push)     r_cnt_ok  <= sat_inc(r_cnt_ok);
            if (w_err_load) r_cnt_err <= sat_inc(r_cnt_err);
        end
    end

    assign cnt_ok  = r_cnt_ok;
    assign cnt_err = r_cnt_err;
`else
    assign cnt_ok  = 16'h0000;
    assign cnt_err = 16'h0000;
`endif

endmodule

// File: tb/tb_rdma_rx_remap.sv
`timescale 1ns/1ps
// Scoreboard bench for rdma_rx_remap: a reference window model decides the
// destination of every accepted request, a negedge monitor pops and compares.
module tb_rdma_rx_remap;
    localparam logic [31:0] OFFSET = 32'h8000_0000;
    localparam logic [31:0] WIN    = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [11:0] req_len = '0;
    logic        req_write = 1'b0;
    logic        loc_valid;
    logic        loc_ready = 1'b0;
    logic [31:0] loc_addr;
    logic [11:0] loc_len;
    logic        loc_write;
    logic        err_valid;
    logic        err_ready = 1'b0;
    logic [31:0] err_addr;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    always #5 clk = ~clk;

    rdma_rx_remap dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_write(req_write),
        .loc_valid(loc_valid), .loc_ready(loc_ready),
        .loc_addr(loc_addr), .loc_len(loc_len), .loc_write(loc_write),
        .err_valid(err_valid), .err_ready(err_ready), .err_addr(err_addr),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    typedef struct { logic [31:0] a; logic [11:0] l; logic w; } loc_t;
    loc_t        loc_q[$];
    logic [31:0] err_q[$];
    loc_t        mon_e;
    logic [31:0] mon_ea;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference legality: whole byte range must lie in the window (64-bit math).
    function automatic bit model_ok(input logic [31:0] a, input logic [11:0] l);
        if (l == 12'd0) return 1'b0;
        if (a < OFFSET) return 1'b0;
        return (64'(a) + 64'(l)) <= (64'(OFFSET) + 64'(WIN));
    endfunction

    // Monitor: transfers are committed when valid&&ready is seen before the edge.
    always @(negedge clk) begin
        #3;
        if (rst_n && loc_valid && loc_ready) begin
            n_checks++;
            if (loc_q.size() == 0) begin
                n_fail++;
                $display("FAIL loc_unexpected: got addr %h len %h wr %b, required no output", loc_addr, loc_len, loc_write);
            end else begin
                mon_e = loc_q.pop_front();
                if ({loc_addr, loc_len, loc_write} !== {mon_e.a, mon_e.l, mon_e.w}) begin
                    n_fail++;
                    $display("FAIL loc_data: got %h/%h/%b, required %h/%h/%b", loc_addr, loc_len, loc_write, mon_e.a, mon_e.l, mon_e.w);
                end
            end
        end
        if (rst_n && err_valid && err_ready) begin
            n_checks++;
            if (err_q.size() == 0) begin
                n_fail++;
                $display("FAIL err_unexpected: got err_addr %h, required no output", err_addr);
            end else begin
                mon_ea = err_q.pop_front();
                if (err_addr !== mon_ea) begin
                    n_fail++;
                    $display("FAIL err_data: got %h, required %h", err_addr, mon_ea);
                end
            end
        end
    end

    // Drive one request at a negedge; wait up to budget cycles for ready.
    task automatic send(input logic [31:0] a, input logic [11:0] l, input logic w,
                        input int budget, output bit acc);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_len = l; req_write = w;
        #1;
        while (!req_ready && t < budget) begin
            @(negedge clk); #1; t++;
        end
        acc = req_ready;
        if (!acc) begin
            req_valid = 1'b0;
        end else begin
            if (model_ok(a, l)) loc_q.push_back('{a - OFFSET, l, w});
            else                err_q.push_back(a);
            @(posedge clk);
        end
    endtask

    task automatic send_chk(input logic [31:0] a, input logic [11:0] l, input logic w);
        bit acc;
        send(a, l, w, 20, acc);
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: addr %h got req_ready 0, required 1 within 20 cycles", a);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((loc_q.size() != 0 || err_q.size() != 0) && t < 60) begin
            @(negedge clk); #4; t++;
        end
        @(negedge clk); #4;
        n_checks++;
        if (loc_q.size() != 0 || err_q.size() != 0 || loc_valid !== 1'b0 || err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got loc_q %0d err_q %0d loc_valid %b err_valid %b, required all 0",
                     name, loc_q.size(), err_q.size(), loc_valid, err_valid);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        loc_q.delete(); err_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({loc_valid, err_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got loc_valid/err_valid/req_ready %b%b%b, required 001", loc_valid, err_valid, req_ready);
        end
        n_checks++;
        if ({loc_addr, loc_len, loc_write, err_addr, cnt_ok, cnt_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got loc_addr %h err_addr %h cnt %h/%h, required 0", loc_addr, err_addr, cnt_ok, cnt_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_translate();
        loc_ready = 1'b1; err_ready = 1'b1;
        send_chk(32'h8000_0040, 12'd64, 1'b0);
        @(negedge clk); req_valid = 1'b0; #2;
        n_checks++;
        if (loc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL translate_early: got loc_valid %b one cycle after accept, required 0", loc_valid);
        end
        @(negedge clk); #2;
        n_checks++;
        if ({loc_valid, loc_addr, loc_len, loc_write} !== {1'b1, 32'h0000_0040, 12'd64, 1'b0}) begin
            n_fail++;
            $display("FAIL translate: got v %b addr %h len %0d wr %b, required v 1 addr 00000040 len 64 wr 0",
                     loc_valid, loc_addr, loc_len, loc_write);
        end
        drain("translate");
    endtask

    task automatic test_window();
        loc_ready = 1'b1; err_ready = 1'b1;
        send_chk(32'h8FFF_FFC0, 12'd64, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); #2;
        n_checks++;
        if ({loc_valid, err_valid, loc_addr} !== {1'b1, 1'b0, 32'h0FFF_FFC0}) begin
            n_fail++;
            $display("FAIL win_top_ok: got loc_v %b err_v %b loc_addr %h, required 1 0 0fffffc0", loc_valid, err_valid, loc_addr);
        end
        drain("win_top_ok");
        send_chk(32'h8FFF_FFC0, 12'd65, 1'b0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); #2;
        n_checks++;
        if ({err_valid, loc_valid, err_addr} !== {1'b1, 1'b0, 32'h8FFF_FFC0}) begin
            n_fail++;
            $display("FAIL win_top_err: got err_v %b loc_v %b err_addr %h, required 1 0 8fffffc0", err_valid, loc_valid, err_addr);
        end
        drain("win_top_err");
        send_chk(32'h7FFF_FFFF, 12'd1,    1'b0);
        send_chk(32'h8000_1000, 12'd0,    1'b1);
        send_chk(32'hFFFF_FFF0, 12'h020,  1'b0);
        send_chk(32'h8FFF_FFFF, 12'd1,    1'b1);
        send_chk(32'h8000_0000, 12'd1,    1'b0);
        send_chk(32'h9000_0000, 12'd1,    1'b0);
        send_chk(32'h8000_0000, 12'hFFF,  1'b1);
        idle(1);
        drain("window");
    endtask

    task automatic test_backpressure();
        bit acc;
        int n_acc = 0;
        loc_ready = 1'b0; err_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(32'h8000_2000 + 32'(i * 64), 12'd32, i[0], 0, acc);
            if (acc) n_acc++;
        end
        #1;
        n_checks++;
        if (n_acc != 5 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_capacity: got %0d accepted req_ready %b, required 5 accepted req_ready 0", n_acc, req_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({loc_valid, loc_addr, req_ready} !== {1'b1, 32'h0000_2000, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold: got loc_v %b loc_addr %h req_ready %b, required 1 00002000 0", loc_valid, loc_addr, req_ready);
        end
        @(negedge clk);
        loc_ready = 1'b1;
        send_chk(32'h8000_2000 + 32'(5 * 64), 12'd32, 1'b1);
        idle(1);
        drain("backpressure");
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n_acc = 0;
        loc_ready = 1'b1; err_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h8123_0000 + 32'(i * 16), 12'(i + 1), i[1], 0, acc);
            if (acc) n_acc++;
        end
        n_checks++;
        if (n_acc != 8) begin
            n_fail++;
            $display("FAIL b2b_rate: got %0d of 8 accepted without stall, required 8", n_acc);
        end
        idle(1);
        drain("b2b");
    endtask

    task automatic test_ordering();
        bit acc;
        loc_ready = 1'b1; err_ready = 1'b0;
        send_chk(32'h1000_0000, 12'd4, 1'b0);
        send_chk(32'h8000_3000, 12'd8, 1'b1);
        send_chk(32'h0000_0010, 12'd4, 1'b0);
        send(32'h8000_3040, 12'd8, 1'b0, 0, acc);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (acc || req_ready !== 1'b0 || loc_valid !== 1'b0 || loc_q.size() != 0) begin
            n_fail++;
            $display("FAIL order_block: got acc %b req_ready %b loc_valid %b loc_q %0d, required 0 0 0 0",
                     acc, req_ready, loc_valid, loc_q.size());
        end
        @(negedge clk);
        err_ready = 1'b1;
        send_chk(32'h8000_3040, 12'd8, 1'b0);
        idle(1);
        drain("ordering");
    endtask

    task automatic test_reset_mid();
        loc_ready = 1'b0; err_ready = 1'b0;
        send_chk(32'h8000_4000, 12'd16, 1'b0);
        send_chk(32'h8000_4010, 12'd16, 1'b1);
        send_chk(32'h8000_4020, 12'd16, 1'b0);
        send_chk(32'h0000_4000, 12'd16, 1'b0);
        idle(2);
        #1;
        n_checks++;
        if ({loc_valid, err_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_setup: got loc_v %b err_v %b, required 1 1", loc_valid, err_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({loc_valid, err_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_async: got loc_v %b err_v %b during reset, required 0 0", loc_valid, err_valid);
        end
        loc_q.delete(); err_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, loc_valid, err_valid, cnt_ok, cnt_err, loc_addr} !== {3'b100, 16'h0, 16'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_after: got req_ready %b loc_v %b err_v %b cnt %h/%h loc_addr %h, required 1 0 0 0/0 0",
                     req_ready, loc_valid, err_valid, cnt_ok, cnt_err, loc_addr);
        end
        loc_ready = 1'b1; err_ready = 1'b1;
    endtask

    task automatic test_stats();
        logic [15:0] exp_ok;
        logic [15:0] exp_err;
        pulse_reset();
        loc_ready = 1'b1; err_ready = 1'b1;
        send_chk(32'h8000_5000, 12'd4, 1'b0);
        send_chk(32'h7000_0000, 12'd4, 1'b0);
        send_chk(32'h8000_5004, 12'd4, 1'b1);
        send_chk(32'h8000_5008, 12'd0, 1'b1);
        send_chk(32'h8000_500C, 12'd4, 1'b0);
        idle(1);
        drain("stats");
`ifdef RDMA_RX_STATS_EN
        exp_ok = 16'd3; exp_err = 16'd2;
`else
        exp_ok = 16'd0; exp_err = 16'd0;
`endif
        n_checks++;
        if (cnt_ok !== exp_ok || cnt_err !== exp_err) begin
            n_fail++;
            $display("FAIL stats_count: got ok %0d err %0d, required ok %0d err %0d", cnt_ok, cnt_err, exp_ok, exp_err);
        end
`ifdef RDMA_RX_STATS_EN
        for (int i = 0; i < 70000; i++) send_chk(32'h0000_0100, 12'd8, 1'b0);
        idle(1);
        drain("stats_sat");
        n_checks++;
        if (cnt_err !== 16'hFFFF || cnt_ok !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_sat: got ok %h err %h, required ok 0003 err ffff", cnt_ok, cnt_err);
        end
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_translate();
        test_window();
        test_backpressure();
        test_back_to_back();
        test_ordering();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
